keypad_scanner: RTL

//   Scans a 4x4 active-low key matrix and produces the debounced 16-bit

---
 rtl/keypad_scanner_if.sv | 10 +
 rtl/keypad_scanner.sv | 88 ++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Pin-side bundle of the keypad scanner: matrix lines plus the debounced key vector.
interface keypad_scanner_if;
  logic [3:0]  i_col_n;
  logic [3:0]  o_row_n;
  logic [15:0] o_key;
  logic        o_changed;

  modport master (output i_col_n, input o_row_n, o_key, o_changed);
  modport slave  (input i_col_n, output o_row_n, o_key, o_changed);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix scanner with frame-level debounce; key[4*r+c] = 1 while held.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DB_CNT   = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  keypad_scanner_if.slave bus
);
  localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    STB_MAX  = 4'(DB_CNT);

  logic [3:0]    r_col_s1, r_col_s2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_row;
  logic [3:0]    r_row_n;
  logic [15:0]   r_raw, r_prev, r_key;
  logic [3:0]    r_stable;
  logic          r_changed;

  logic          w_samp, w_frame_end, w_commit;
  logic [1:0]    w_row_nxt;
  logic [15:0]   w_frame;
  logic [3:0]    w_stable_nxt;

  assign w_samp      = (r_div == DIV_LAST);
  assign w_frame_end = w_samp && (r_row == 2'd3);
  assign w_row_nxt   = w_samp ? r_row + 2'd1 : r_row;
  // Row 3 is still in the synchroniser at frame end, so splice it in directly.
  assign w_frame     = {~r_col_s2, r_raw[11:0]};

  always_comb begin
    w_stable_nxt = 4'd1;
    if (w_frame == r_prev)
      w_stable_nxt = (r_stable >= STB_MAX) ? STB_MAX : r_stable + 4'd1;
  end

  assign w_commit = w_frame_end && (w_stable_nxt == STB_MAX) && (w_frame != r_key);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= bus.i_col_n;
      r_col_s2 <= r_col_s1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_row   <= 2'd0;
      r_row_n <= 4'hF;
    end else begin
      r_div   <= w_samp ? '0 : r_div + DW'(1);
      r_row   <= w_row_nxt;
      r_row_n <= ~(4'b0001 << w_row_nxt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_raw     <= '0;
      r_prev    <= '0;
      r_stable  <= 4'd0;
      r_key     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (w_samp)
        r_raw[4*r_row +: 4] <= ~r_col_s2;
      if (w_frame_end) begin
        r_prev   <= w_frame;
        r_stable <= w_stable_nxt;
        if (w_commit) begin
          r_key     <= w_frame;
          r_changed <= 1'b1;
        end
      end
    end
  end

  assign bus.o_row_n   = r_row_n;
  assign bus.o_key     = r_key;
  assign bus.o_changed = r_changed;
endmodule
